census_disparity_engine: RTL

//  Parametrised successor census-cost correlator for the stereo pipeline. Sits between the census

---
 rtl/census_disparity_engine.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/census_disparity_engine.sv
// census_disparity_engine: census Hamming-cost correlator picking the min-cost disparity per pixel.
// Ports: clk, reset (sync, active-high); in_valid/in_sol/left_bitvec/right_bitvec/pixel_x/pixel_y in;
//   out_valid/out_disp/out_cost/out_x/out_y/out_unique out. Fixed latency clog2(NUM_DISP)+1, no stalls.
// Optional: define CORR_UNIQUENESS_EN to track second-best cost and drive a real out_unique flag.
module census_disparity_engine #(
  parameter int NUM_DISP    = 64,
  parameter int BV_LEN      = 72,
  parameter int COORD_W     = 10,
  parameter int UNIQ_MARGIN = 4,
  localparam int LVL = $clog2(NUM_DISP),
  localparam int CW  = $clog2(BV_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               in_sol,
  input  logic [BV_LEN-1:0]  left_bitvec,
  input  logic [BV_LEN-1:0]  right_bitvec,
  input  logic [COORD_W-1:0] pixel_x,
  input  logic [COORD_W-1:0] pixel_y,
  output logic               out_valid,
  output logic [LVL-1:0]     out_disp,
  output logic [CW-1:0]      out_cost,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y,
  output logic               out_unique
);

  // Right-vector history, registered left vector and the fill count that masks stale history.
  logic [BV_LEN-1:0]  hist [NUM_DISP];
  logic [BV_LEN-1:0]  left_q;
  logic [LVL:0]       fill;

  // vld_pipe[j] / x_pipe[j] / y_pipe[j] belong to the pixel sampled j edges ago.
  logic [LVL:0]       vld_pipe;
  logic [COORD_W-1:0] x_pipe [LVL+1];
  logic [COORD_W-1:0] y_pipe [LVL+1];

  // Min tree stored heap-style: leaves at NUM_DISP+d, node i merges 2i (lower d) and 2i+1.
  // Node 1 (the root) is not stored; it is merged straight into the output registers.
  logic [CW-1:0]      node_cost [2:2*NUM_DISP-1];
  logic [LVL-1:0]     node_idx  [2:2*NUM_DISP-1];
`ifdef CORR_UNIQUENESS_EN
  logic [CW-1:0]      node_sec  [2:2*NUM_DISP-1];

  function automatic logic [CW-1:0] min_c(input logic [CW-1:0] a, input logic [CW-1:0] b);
    return (a < b) ? a : b;
  endfunction
`endif

  logic root_upper;
  logic uniq_ok;

  // Valid bits and fill counter are the only reset state.
  always_ff @(posedge clk) begin
    if (reset) begin
      fill     <= '0;
      vld_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[LVL-1:0], in_valid};
      if (in_valid) begin
        if (in_sol) begin
          fill <= (LVL+1)'(1);
        end else if (fill != (LVL+1)'(NUM_DISP)) begin
          fill <= fill + 1'b1;
        end
      end
    end
  end

  // Input capture and coordinate pipeline; history only moves on accepted pixels.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      hist[0]   <= right_bitvec;
      for (int d = 1; d < NUM_DISP; d++) begin
        hist[d] <= hist[d-1];
      end
      left_q    <= left_bitvec;
      x_pipe[0] <= pixel_x;
      y_pipe[0] <= pixel_y;
    end
    for (int s = 1; s <= LVL; s++) begin
      x_pipe[s] <= x_pipe[s-1];
      y_pipe[s] <= y_pipe[s-1];
    end
  end

  // Cost leaves plus all internal tree levels. fill still describes the pixel in left_q here,
  // because any newer pixel updates fill on this same edge.
  always_ff @(posedge clk) begin
    for (int d = 0; d < NUM_DISP; d++) begin
      node_idx[NUM_DISP+d] <= LVL'(d);
      if (d < int'(fill)) begin
        node_cost[NUM_DISP+d] <= CW'($countones(left_q ^ hist[d]));
      end else begin
        node_cost[NUM_DISP+d] <= '1;
      end
`ifdef CORR_UNIQUENESS_EN
      node_sec[NUM_DISP+d] <= '1;
`endif
    end
    for (int i = 2; i < NUM_DISP; i++) begin
      // Upper operand wins only when strictly cheaper, so ties resolve to the lower disparity.
      if (node_cost[2*i+1] < node_cost[2*i]) begin
        node_cost[i] <= node_cost[2*i+1];
        node_idx[i]  <= node_idx[2*i+1];
`ifdef CORR_UNIQUENESS_EN
        node_sec[i]  <= min_c(node_cost[2*i], node_sec[2*i+1]);
`endif
      end else begin
        node_cost[i] <= node_cost[2*i];
        node_idx[i]  <= node_idx[2*i];
`ifdef CORR_UNIQUENESS_EN
        node_sec[i]  <= min_c(node_cost[2*i+1], node_sec[2*i]);
`endif
      end
    end
  end

  assign root_upper = node_cost[3] < node_cost[2];

`ifdef CORR_UNIQUENESS_EN
  logic [CW-1:0] root_best;
  logic [CW-1:0] root_sec;
  assign root_best = root_upper ? node_cost[3] : node_cost[2];
  assign root_sec  = root_upper ? min_c(node_cost[2], node_sec[3])
                                : min_c(node_cost[3], node_sec[2]);
  assign uniq_ok   = (root_sec - root_best) >= CW'(UNIQ_MARGIN);
`else
  assign uniq_ok   = 1'b1;
`endif

  // Output stage: data holds between results so idle outputs stay at their last (or reset) value.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_disp   <= '0;
      out_cost   <= '0;
      out_x      <= '0;
      out_y      <= '0;
      out_unique <= 1'b0;
    end else begin
      out_valid  <= vld_pipe[LVL];
      out_unique <= vld_pipe[LVL] & uniq_ok;
      if (vld_pipe[LVL]) begin
        out_disp <= root_upper ? node_idx[3]  : node_idx[2];
        out_cost <= root_upper ? node_cost[3] : node_cost[2];
        out_x    <= x_pipe[LVL];
        out_y    <= y_pipe[LVL];
      end
    end
  end

endmodule
